// File: rtl/pong_menu_ctrl_pkg.sv
// Shared types and constants for the title-menu controller.
package pong_menu_ctrl_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned PIX_W   = 8;

    typedef enum logic [1:0] {
        ST_MENU   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_PLAY   = 2'd2
    } state_e;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb_t;

    localparam logic [COORD_W-1:0] OFFSCREEN = 10'h3FF;
    localparam logic [PIX_W-1:0]   RGB_BLACK = 8'h00;

    // Halve every channel for non-selected items.
    function automatic rgb_t rgb_dim(input rgb_t p);
        rgb_t o;
        o.r = {1'b0, p.r[2:1]};
        o.g = {1'b0, p.g[2:1]};
        o.b = {1'b0, p.b[1]};
        return o;
    endfunction

endpackage

// File: rtl/pong_menu_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, and a
// 1-cycle pulse on the accepted 0->1 transition.
module pong_btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    // The counter tracks consecutive samples that disagree with the accepted level.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        cnt_d   = '0;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/pong_menu_ctrl.sv
// Title-menu controller: menu FSM, screen->ROM coordinate map and pixel mux.
// Optional selected-item blinking is enabled by defining PONG_MENU_BLINK_EN.
module pong_menu_ctrl
    import pong_menu_ctrl_pkg::*;
#(
    parameter int unsigned NUM_ITEMS       = 3,
    parameter int unsigned ITEM_X          = 288,
    parameter int unsigned ITEM_Y0         = 200,
    parameter int unsigned ITEM_PITCH      = 32,
    parameter int unsigned ITEM_W          = 64,
    parameter int unsigned ITEM_H          = 16,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned BLINK_FRAMES    = 30
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           btn_up,
    input  logic                           btn_down,
    input  logic                           btn_sel,
    input  logic [9:0]                     xpos,
    input  logic [9:0]                     ypos,
    input  logic                           game_over,
    input  logic [8*NUM_ITEMS-1:0]         item_rgb,
    output logic [9:0]                     rom_xpos,
    output logic [9:0]                     rom_ypos,
    output logic [2:0]                     red,
    output logic [2:0]                     green,
    output logic [1:0]                     blue,
    output logic [$clog2(NUM_ITEMS)-1:0]   sel_idx,
    output logic [$clog2(NUM_ITEMS)-1:0]   game_mode,
    output logic                           start_game,
    output logic                           menu_active
);

    localparam int unsigned IDX_W = $clog2(NUM_ITEMS);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_ITEMS - 1);
    localparam logic [COORD_W-1:0] X_LO     = COORD_W'(ITEM_X);
    localparam logic [COORD_W-1:0] X_HI     = COORD_W'(ITEM_X + ITEM_W);
    localparam logic [COORD_W-1:0] Y_H      = COORD_W'(ITEM_H);

    if (NUM_ITEMS < 2 || NUM_ITEMS > 8 || DEBOUNCE_CYCLES == 0 || BLINK_FRAMES == 0 ||
        ITEM_Y0 + (NUM_ITEMS - 1) * ITEM_PITCH + ITEM_H > 480) begin : g_param_err
        $error("pong_menu_ctrl: illegal parameter set");
    end

    logic up_p, down_p, sel_p;

    pong_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_up), .press(up_p)
    );
    pong_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_down), .press(down_p)
    );
    pong_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_sel (
        .clk(clk), .rst_n(rst_n), .btn_raw(btn_sel), .press(sel_p)
    );

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sel_idx_q, sel_idx_d;
    logic [IDX_W-1:0] game_mode_q, game_mode_d;
    logic             start_game_q, start_game_d;
    logic             menu_active_q, menu_active_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] hit_idx_q, hit_idx_d;
    logic             blank_c;

    // Menu FSM; registered outputs are derived from the next state.
    always_comb begin
        state_d     = state_q;
        sel_idx_d   = sel_idx_q;
        game_mode_d = game_mode_q;
        unique case (state_q)
            ST_MENU: begin
                if (sel_p) begin
                    state_d     = ST_LAUNCH;
                    game_mode_d = sel_idx_q;
                end else if (up_p && !down_p) begin
                    sel_idx_d = (sel_idx_q == '0) ? IDX_LAST : sel_idx_q - IDX_W'(1);
                end else if (down_p && !up_p) begin
                    sel_idx_d = (sel_idx_q == IDX_LAST) ? '0 : sel_idx_q + IDX_W'(1);
                end
            end
            ST_LAUNCH: state_d = ST_PLAY;
            ST_PLAY:   if (game_over) state_d = ST_MENU;
            default:   state_d = ST_MENU;
        endcase
        start_game_d  = (state_d == ST_LAUNCH);
        menu_active_d = (state_d == ST_MENU);
    end

    // Screen -> ROM-local coordinate map, active only in MENU.
    logic [COORD_W-1:0] rom_x_c, rom_y_c, y_top_c;
    always_comb begin
        hit_d     = 1'b0;
        hit_idx_d = '0;
        rom_x_c   = OFFSCREEN;
        rom_y_c   = OFFSCREEN;
        y_top_c   = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            y_top_c = COORD_W'(ITEM_Y0 + i * ITEM_PITCH);
            if (state_q == ST_MENU && xpos >= X_LO && xpos < X_HI &&
                ypos >= y_top_c && ypos < y_top_c + Y_H) begin
                hit_d     = 1'b1;
                hit_idx_d = IDX_W'(i);
                rom_x_c   = xpos - X_LO;
                rom_y_c   = ypos - y_top_c;
            end
        end
    end

    assign rom_xpos = rom_x_c;
    assign rom_ypos = rom_y_c;

    // Pixel mux, one cycle behind the coordinates to match ROM latency.
    rgb_t raw_c, pix_c;
    always_comb begin
        raw_c = rgb_t'(RGB_BLACK);
        pix_c = rgb_t'(RGB_BLACK);
        for (int i = 0; i < NUM_ITEMS; i++) begin
            if (hit_idx_q == IDX_W'(i)) raw_c = rgb_t'(item_rgb[8*i +: 8]);
        end
        if (hit_q && state_q == ST_MENU) begin
            if (hit_idx_q != sel_idx_q) pix_c = rgb_dim(raw_c);
            else if (!blank_c)          pix_c = raw_c;
        end
    end

    assign red   = pix_c.r;
    assign green = pix_c.g;
    assign blue  = pix_c.b;

`ifdef PONG_MENU_BLINK_EN
    localparam int unsigned FRAME_W = $clog2(BLINK_FRAMES + 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

    logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
    logic               phase_q, phase_d;

    // Blink phase restarts whenever the selection moves so the new item shows at once.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (sel_idx_d != sel_idx_q) begin
            frame_cnt_d = '0;
            phase_d     = 1'b0;
        end else if (xpos == '0 && ypos == '0) begin
            if (frame_cnt_q == FRAME_LAST) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + FRAME_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign blank_c = phase_q;
`else
    assign blank_c = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_MENU;
            sel_idx_q     <= '0;
            game_mode_q   <= '0;
            start_game_q  <= 1'b0;
            menu_active_q <= 1'b1;
            hit_q         <= 1'b0;
            hit_idx_q     <= '0;
        end else begin
            state_q       <= state_d;
            sel_idx_q     <= sel_idx_d;
            game_mode_q   <= game_mode_d;
            start_game_q  <= start_game_d;
            menu_active_q <= menu_active_d;
            hit_q         <= hit_d;
            hit_idx_q     <= hit_idx_d;
        end
    end

    assign sel_idx     = sel_idx_q;
    assign game_mode   = game_mode_q;
    assign start_game  = start_game_q;
    assign menu_active = menu_active_q;

endmodule

// File: tb/tb_pong_menu_ctrl.sv
// Directed self-checking bench for pong_menu_ctrl (debounce 4, blink 2 frames).
module tb_pong_menu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_up, btn_down, btn_sel;
    logic [9:0]  xpos, ypos;
    logic        game_over;
    logic [23:0] item_rgb;
    logic [9:0]  rom_xpos, rom_ypos;
    logic [2:0]  red, green;
    logic [1:0]  blue;
    logic [1:0]  sel_idx, game_mode;
    logic        start_game, menu_active;

    int checks = 0;
    int errors = 0;
    int launches;

    localparam logic [7:0] FULL = 8'hFF;
    localparam logic [7:0] DIM  = 8'h6D;
    localparam logic [7:0] OFF  = 8'h00;

    pong_menu_ctrl #(.DEBOUNCE_CYCLES(4), .BLINK_FRAMES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_up(btn_up), .btn_down(btn_down), .btn_sel(btn_sel),
        .xpos(xpos), .ypos(ypos), .game_over(game_over), .item_rgb(item_rgb),
        .rom_xpos(rom_xpos), .rom_ypos(rom_ypos),
        .red(red), .green(green), .blue(blue),
        .sel_idx(sel_idx), .game_mode(game_mode),
        .start_game(start_game), .menu_active(menu_active)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic u, input logic d, input logic s);
        btn_up = u; btn_down = d; btn_sel = s;
        repeat (10) tick();
        btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
        repeat (10) tick();
    endtask

    task automatic frame();
        xpos = 10'd0; ypos = 10'd0;
        tick();
        xpos = 10'd290; ypos = 10'd235;
        tick();
    endtask

    initial begin
        rst_n = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_sel = 1'b0;
        xpos = 10'd10; ypos = 10'd10; game_over = 1'b0; item_rgb = {3{FULL}};
        #12;
        chk("rst_sel", 32'(sel_idx), 0);
        chk("rst_mode", 32'(game_mode), 0);
        chk("rst_start", 32'(start_game), 0);
        chk("rst_active", 32'(menu_active), 1);
        chk("rst_rgb", 32'({red, green, blue}), 32'(OFF));

        // Reset in the middle of a press
        rst_n = 1'b1; tick();
        btn_down = 1'b1; repeat (3) tick();
        rst_n = 1'b0; tick();
        rst_n = 1'b1; btn_down = 1'b0;
        repeat (12) tick();
        chk("midrst_sel", 32'(sel_idx), 0);
        chk("midrst_start", 32'(start_game), 0);
        chk("midrst_active", 32'(menu_active), 1);

        // Wrap both directions, simultaneous press, glitch rejection
        press(1'b1, 1'b0, 1'b0); chk("up_wrap", 32'(sel_idx), 2);
        press(1'b0, 1'b1, 1'b0); chk("down_wrap", 32'(sel_idx), 0);
        press(1'b0, 1'b1, 1'b0); chk("down1", 32'(sel_idx), 1);
        press(1'b0, 1'b1, 1'b0); chk("down2", 32'(sel_idx), 2);
        press(1'b1, 1'b1, 1'b0); chk("up_down_same", 32'(sel_idx), 2);
        btn_down = 1'b1; repeat (3) tick(); btn_down = 1'b0;
        repeat (10) tick();
        chk("glitch", 32'(sel_idx), 2);
        press(1'b1, 1'b0, 1'b0); chk("up_to1", 32'(sel_idx), 1);

        // Launch, play, return
        btn_sel = 1'b1;
        launches = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (start_game) begin
                launches++;
                chk("launch_mode", 32'(game_mode), 1);
                chk("launch_active", 32'(menu_active), 0);
            end
        end
        chk("launch_count", 32'(launches), 1);
        chk("play_active", 32'(menu_active), 0);
        xpos = 10'd290; ypos = 10'd235; #1;
        chk("play_romx", 32'(rom_xpos), 32'h3FF);
        chk("play_romy", 32'(rom_ypos), 32'h3FF);
        tick();
        chk("play_rgb", 32'({red, green, blue}), 32'(OFF));
        btn_down = 1'b1; repeat (10) tick(); btn_down = 1'b0; repeat (10) tick();
        chk("play_btn_ignored", 32'(sel_idx), 1);
        game_over = 1'b1; tick(); game_over = 1'b0;
        chk("ret_active", 32'(menu_active), 1);
        chk("ret_sel", 32'(sel_idx), 1);
        launches = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (start_game) launches++;
        end
        chk("held_sel_no_relaunch", 32'(launches), 0);
        btn_sel = 1'b0; repeat (10) tick();
        game_over = 1'b1; tick(); game_over = 1'b0; tick();
        chk("gameover_in_menu", 32'(menu_active), 1);
        chk("gameover_in_menu_start", 32'(start_game), 0);

        // Coordinate map
        xpos = 10'd290; ypos = 10'd235; #1;
        chk("map_romx", 32'(rom_xpos), 2);
        chk("map_romy", 32'(rom_ypos), 3);
        xpos = 10'd10; ypos = 10'd10; #1;
        chk("miss_romx", 32'(rom_xpos), 32'h3FF);
        chk("miss_romy", 32'(rom_ypos), 32'h3FF);
        xpos = 10'd351; ypos = 10'd215; #1;
        chk("edge_romx", 32'(rom_xpos), 63);
        chk("edge_romy", 32'(rom_ypos), 15);
        xpos = 10'd352; #1;
        chk("xhi_miss", 32'(rom_xpos), 32'h3FF);
        xpos = 10'd288; ypos = 10'd216; #1;
        chk("yhi_miss", 32'(rom_ypos), 32'h3FF);

        // Pixel composite with one-cycle latency
        xpos = 10'd10; ypos = 10'd10; tick();
        xpos = 10'd290; ypos = 10'd235; #1;
        chk("pix_latency", 32'({red, green, blue}), 32'(OFF));
        tick();
        chk("pix_selected", 32'({red, green, blue}), 32'(FULL));
        xpos = 10'd290; ypos = 10'd205; tick();
        chk("pix_dimmed", 32'({red, green, blue}), 32'(DIM));
        xpos = 10'd290; ypos = 10'd235; tick();

        // Blink of the selected item
        chk("blink_f0", 32'({red, green, blue}), 32'(FULL));
        frame(); chk("blink_f1", 32'({red, green, blue}), 32'(FULL));
`ifdef PONG_MENU_BLINK_EN
        frame(); chk("blink_f2", 32'({red, green, blue}), 32'(OFF));
        frame(); chk("blink_f3", 32'({red, green, blue}), 32'(OFF));
        frame(); chk("blink_f4", 32'({red, green, blue}), 32'(FULL));
        frame(); frame(); chk("blink_f6", 32'({red, green, blue}), 32'(OFF));
`else
        frame(); chk("noblink_f2", 32'({red, green, blue}), 32'(FULL));
        frame(); chk("noblink_f3", 32'({red, green, blue}), 32'(FULL));
        frame(); frame(); frame(); chk("noblink_f6", 32'({red, green, blue}), 32'(FULL));
`endif
        press(1'b0, 1'b1, 1'b0);
        chk("blink_sel2", 32'(sel_idx), 2);
        xpos = 10'd290; ypos = 10'd270; tick();
        chk("blink_restart", 32'({red, green, blue}), 32'(FULL));
        xpos = 10'd290; ypos = 10'd235; tick();
        chk("old_item_dim", 32'({red, green, blue}), 32'(DIM));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
